// File: rtl/signal_mux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// signal_mux_pkg : constants and state type shared by the input-mux scan logic
// Revision 1.0
// ---------------------------------------------------------------------------
package signal_mux_pkg;

  localparam int NUM_SRC = 13;
  localparam int SEL_W   = 5;

  localparam logic [SEL_W-1:0] SEL_IMI = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_DUMP   = 2'd3
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/mask_next_src.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mask_next_src : next set mask bit strictly above cur, with wraparound flag
// Revision 1.0
// ---------------------------------------------------------------------------
module mask_next_src
  import signal_mux_pkg::*;
(
  input  logic [NUM_SRC-1:0] mask,
  input  logic [SEL_W-1:0]   cur,
  output logic [SEL_W-1:0]   nxt,
  output logic               wrap
);

  logic [SEL_W:0]     pos_raw;
  logic [SEL_W-1:0]   pos;
  logic [NUM_SRC-1:0] shifted;
  logic               found;

  // Walk the mask rotated to start just above cur; first hit wins.
  always_comb begin
    nxt     = cur;
    wrap    = 1'b1;
    found   = 1'b0;
    pos_raw = '0;
    pos     = '0;
    shifted = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      pos_raw = {1'b0, cur} + (SEL_W+1)'(i);
      if (pos_raw >= (SEL_W+1)'(NUM_SRC)) begin
        pos = SEL_W'(pos_raw - (SEL_W+1)'(NUM_SRC));
      end else begin
        pos = pos_raw[SEL_W-1:0];
      end
      shifted = mask >> pos;
      if (!found && shifted[0]) begin
        found = 1'b1;
        nxt   = pos;
        wrap  = (pos_raw >= (SEL_W+1)'(NUM_SRC));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/signal_mux_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// signal_mux_scan_ctrl : steps the correlator input mux over enabled sources,
// framing settle / accumulate / dump phases per source
// Revision 1.0
// ---------------------------------------------------------------------------
module signal_mux_scan_ctrl
  import signal_mux_pkg::*;
#(
  parameter int DWELL_W  = 16,
  parameter int SETTLE_W = 4
) (
  input  logic                pclk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic [NUM_SRC-1:0]  cfg_mask,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic                cfg_loop,
  output logic [SEL_W-1:0]    input_reg_re,
  output logic [SEL_W-1:0]    input_reg_im,
  output logic                acc_clr,
  output logic                acc_en,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [SEL_W-1:0]    dump_src,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  scan_state_e         state_q, state_d;
  logic [SEL_W-1:0]    cur_q, cur_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [NUM_SRC-1:0]  mask_q, mask_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                loop_q, loop_d;
  logic                done_d, cfg_err_d;

  logic [SEL_W-1:0]    sel_q, src_q;
  logic                busy_q, acc_en_q, acc_clr_q, dump_valid_q, done_q, cfg_err_q;

  logic [NUM_SRC-1:0]  srch_mask;
  logic [SEL_W-1:0]    srch_cur, srch_nxt;
  logic                srch_wrap;
  logic [DWELL_W-1:0]  dwell_eff;
  logic [SETTLE_W-1:0] settle_eff;

  // In IDLE, searching above the top index yields the lowest set bit of the new mask.
  assign srch_mask = (state_q == ST_IDLE) ? cfg_mask : mask_q;
  assign srch_cur  = (state_q == ST_IDLE) ? SEL_W'(NUM_SRC - 1) : cur_q;

  mask_next_src u_next_src (
    .mask (srch_mask),
    .cur  (srch_cur),
    .nxt  (srch_nxt),
    .wrap (srch_wrap)
  );

  assign dwell_eff  = (cfg_dwell  == '0) ? DWELL_W'(1)  : cfg_dwell;
  assign settle_eff = (cfg_settle == '0) ? SETTLE_W'(1) : cfg_settle;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    dwell_d   = dwell_q;
    settle_d  = settle_q;
    loop_d    = loop_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_mask != '0) begin
              state_d  = ST_SWITCH;
              cur_d    = srch_nxt;
              mask_d   = cfg_mask;
              dwell_d  = dwell_eff;
              settle_d = settle_eff;
              loop_d   = cfg_loop;
              cnt_d    = DWELL_W'(settle_eff) - DWELL_W'(1);
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        ST_SWITCH: begin
          if (cnt_q == '0) begin
            state_d = ST_ACCUM;
            cnt_d   = dwell_q - DWELL_W'(1);
          end else begin
            cnt_d = cnt_q - DWELL_W'(1);
          end
        end
        ST_ACCUM: begin
          if (cnt_q == '0) begin
            state_d = ST_DUMP;
          end else begin
            cnt_d = cnt_q - DWELL_W'(1);
          end
        end
        ST_DUMP: begin
          if (dump_ready) begin
            if (!srch_wrap || loop_q) begin
              state_d = ST_SWITCH;
              cur_d   = srch_nxt;
              cnt_d   = DWELL_W'(settle_q) - DWELL_W'(1);
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      cnt_q        <= '0;
      mask_q       <= '0;
      dwell_q      <= '0;
      settle_q     <= '0;
      loop_q       <= 1'b0;
      sel_q        <= '0;
      src_q        <= '0;
      busy_q       <= 1'b0;
      acc_en_q     <= 1'b0;
      acc_clr_q    <= 1'b0;
      dump_valid_q <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      dwell_q      <= dwell_d;
      settle_q     <= settle_d;
      loop_q       <= loop_d;
      // Outputs are decoded from next state so they align with the state register.
      sel_q        <= (state_d != ST_IDLE) ? cur_d : SEL_IMI;
      src_q        <= (state_d == ST_DUMP) ? cur_d : SEL_IMI;
      busy_q       <= (state_d != ST_IDLE);
      acc_en_q     <= (state_d == ST_ACCUM);
      acc_clr_q    <= (state_d == ST_ACCUM) && (state_q != ST_ACCUM);
      dump_valid_q <= (state_d == ST_DUMP);
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign input_reg_re = sel_q;
  assign input_reg_im = sel_q;
  assign dump_src     = src_q;
  assign busy         = busy_q;
  assign acc_en       = acc_en_q;
  assign acc_clr      = acc_clr_q;
  assign dump_valid   = dump_valid_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_signal_mux_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_signal_mux_scan_ctrl : directed + randomized bench against a timeline model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_signal_mux_scan_ctrl;
  import signal_mux_pkg::*;

  localparam int DWELL_W  = 16;
  localparam int SETTLE_W = 4;

  logic                pclk = 1'b0;
  logic                reset_n, start, stop, cfg_loop, dump_ready;
  logic [NUM_SRC-1:0]  cfg_mask;
  logic [DWELL_W-1:0]  cfg_dwell;
  logic [SETTLE_W-1:0] cfg_settle;
  logic [SEL_W-1:0]    input_reg_re, input_reg_im, dump_src;
  logic                acc_clr, acc_en, dump_valid, busy, done, cfg_err;

  always #5 pclk = ~pclk;

  signal_mux_scan_ctrl #(.DWELL_W(DWELL_W), .SETTLE_W(SETTLE_W)) dut (
    .pclk         (pclk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .cfg_mask     (cfg_mask),
    .cfg_dwell    (cfg_dwell),
    .cfg_settle   (cfg_settle),
    .cfg_loop     (cfg_loop),
    .input_reg_re (input_reg_re),
    .input_reg_im (input_reg_im),
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_src     (dump_src),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: a scan is a list of per-source segments, each starting at
  // m_seg and laid out as S settle cycles, D accumulate cycles, then the dump.
  bit                 m_active;
  int                 m_cur, m_seg, m_s, m_d;
  logic [NUM_SRC-1:0] m_mask;
  bit                 m_loop, e_done, e_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit mask_bit(input logic [NUM_SRC-1:0] m, input int j);
    logic [NUM_SRC-1:0] t;
    t = m >> j;
    return t[0];
  endfunction

  function automatic int lowest_src(input logic [NUM_SRC-1:0] m);
    for (int j = 0; j < NUM_SRC; j++) if (mask_bit(m, j)) return j;
    return 0;
  endfunction

  function automatic int next_src(input logic [NUM_SRC-1:0] m, input int c);
    for (int k = 1; k <= NUM_SRC; k++) if (mask_bit(m, (c + k) % NUM_SRC)) return (c + k) % NUM_SRC;
    return c;
  endfunction

  task automatic check_outputs();
    int         off;
    logic [4:0] esel;
    bit         ebusy, een, eclr, edv;
    esel = '0; ebusy = 0; een = 0; eclr = 0; edv = 0;
    if (m_active) begin
      off   = cyc - m_seg;
      ebusy = 1;
      esel  = m_cur[4:0];
      if (off >= m_s && off < m_s + m_d) begin
        een  = 1;
        eclr = (off == m_s);
      end else if (off >= m_s + m_d) begin
        edv = 1;
      end
    end
    check_eq("busy",         busy,         ebusy);
    check_eq("input_reg_re", input_reg_re, esel);
    check_eq("input_reg_im", input_reg_im, esel);
    check_eq("acc_en",       acc_en,       een);
    check_eq("acc_clr",      acc_clr,      eclr);
    check_eq("dump_valid",   dump_valid,   edv);
    if (edv) check_eq("dump_src", dump_src, esel);
    check_eq("done",         done,         e_done);
    check_eq("cfg_err",      cfg_err,      e_err);
  endtask

  // Advance the model with the inputs currently applied, clock once, compare.
  task automatic tick();
    int off;
    bit nd, ne;
    nd = 0; ne = 0;
    if (!reset_n || stop) begin
      m_active = 0;
    end else if (!m_active) begin
      if (start) begin
        if (cfg_mask != '0) begin
          m_active = 1;
          m_mask   = cfg_mask;
          m_s      = (cfg_settle == '0) ? 1 : int'(cfg_settle);
          m_d      = (cfg_dwell == '0) ? 1 : int'(cfg_dwell);
          m_loop   = cfg_loop;
          m_cur    = lowest_src(cfg_mask);
          m_seg    = cyc + 1;
        end else begin
          ne = 1;
        end
      end
    end else begin
      off = cyc - m_seg;
      if (off >= m_s + m_d && dump_ready) begin
        int nx;
        nx = next_src(m_mask, m_cur);
        if (nx > m_cur || m_loop) begin
          m_cur = nx;
          m_seg = cyc + 1;
        end else begin
          m_active = 0;
          nd = 1;
        end
      end
    end
    e_done = nd;
    e_err  = ne;
    @(posedge pclk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_cfg(input logic [NUM_SRC-1:0] m, input int d, input int s, input bit l);
    cfg_mask   = m;
    cfg_dwell  = DWELL_W'(d);
    cfg_settle = SETTLE_W'(s);
    cfg_loop   = l;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic run_rand(input int n);
    repeat (n) begin
      dump_ready = ($urandom_range(3) != 0);
      start      = ($urandom_range(15) == 0);
      stop       = ($urandom_range(59) == 0);
      set_cfg(NUM_SRC'($urandom), int'($urandom_range(6)), int'($urandom_range(4)), 1'($urandom));
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; dump_ready = 1'b1;
    set_cfg('0, 0, 0, 1'b0);
    m_active = 0; m_cur = 0; m_seg = 0; m_s = 1; m_d = 1; m_mask = '0; m_loop = 0;
    e_done = 0; e_err = 0;

    run(3);
    reset_n = 1'b1;
    tick();

    // One pass over sources 1 and 2
    set_cfg(13'h0006, 4, 2, 1'b0);
    pulse_start();
    run(25);

    // Zero dwell/settle on the imitator
    set_cfg(13'h0001, 0, 0, 1'b0);
    pulse_start();
    run(8);

    // Dump backpressure; config changes mid-scan must be ignored
    set_cfg(13'h0010, 2, 1, 1'b0);
    dump_ready = 1'b0;
    pulse_start();
    set_cfg(13'h1fff, 9, 7, 1'b1);
    run(8);
    dump_ready = 1'b1;
    run(6);

    // Continuous scan with wraparound
    set_cfg(13'h1001, 1, 1, 1'b1);
    pulse_start();
    run(30);
    pulse_stop();
    run(2);

    // Empty mask
    set_cfg('0, 3, 3, 1'b0);
    pulse_start();
    run(3);

    // stop beats start in the same cycle
    set_cfg(13'h0001, 1, 1, 1'b0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    run(2);

    // Abort in ACCUM, restart, then reset while held in DUMP, restart again
    set_cfg(13'h00f0, 8, 1, 1'b1);
    pulse_start();
    run(3);
    pulse_stop();
    run(2);
    pulse_start();
    dump_ready = 1'b0;
    run(10);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    dump_ready = 1'b1;
    run(2);
    pulse_start();
    run(20);
    pulse_stop();
    run(1);

    // Randomized scans
    for (int it = 0; it < 40; it++) begin
      set_cfg(($urandom_range(7) == 0) ? '0 : NUM_SRC'($urandom),
              int'($urandom_range(6)), int'($urandom_range(4)), 1'($urandom));
      pulse_start();
      run_rand(int'($urandom_range(20, 80)));
      pulse_stop();
      run(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
